// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer and its skid buffers.
package stream_demux_pkg;

    typedef enum logic {DEST_OUT0 = 1'b0, DEST_OUT1 = 1'b1} dest_e;

    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam logic [CNT_W-1:0] SKID_FULL = CNT_W'(SKID_DEPTH);

    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] count,
                                                    input logic push,
                                                    input logic pop);
        next_count = count + CNT_W'(push) - CNT_W'(pop);
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO: head register feeds the consumer, tail catches the beat
// that arrives while the head is still stalled.
module skid_fifo2
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= next_count(count_q, push, pop);
            if (push && pop) begin
                // Head leaves; the new beat lands behind whatever remains.
                if (count_q == SKID_FULL) begin
                    head_q <= tail_q;
                    tail_q <= push_data;
                end else begin
                    head_q <= push_data;
                end
            end else if (pop) begin
                head_q <= tail_q;
            end else if (push) begin
                if (count_q == '0) begin
                    head_q <= push_data;
                end else begin
                    tail_q <= push_data;
                end
            end
        end
    end

    assign head_data = head_q;
    assign count     = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= SKID_FULL);
    a_push_room:   assert property (@(posedge clk) disable iff (rst)
                                    push |-> ((count_q < SKID_FULL) || pop));

endmodule

// File: rtl/stream_demux_1to2.sv
// 1:2 valid/ready stream demux with a registered in_ready and a skid FIFO per output.
// Define STREAM_DEMUX_PKT_LOCK_EN to hold the destination for a whole in_last-delimited packet.
module stream_demux_1to2
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
);

    logic [CNT_W-1:0] count0, count1;
    logic [CNT_W-1:0] count0_next, count1_next;
    logic             accept, push0, push1, pop0, pop1;
    logic             in_ready_q, room_next;
    logic             next_sel_known;
    dest_e            eff_sel, next_sel;

    assign in_ready    = in_ready_q && !rst;
    assign accept      = in_valid && in_ready;
    assign push0       = accept && (eff_sel == DEST_OUT0);
    assign push1       = accept && (eff_sel == DEST_OUT1);
    assign out0_valid  = (count0 != '0);
    assign out1_valid  = (count1 != '0);
    assign pop0        = out0_valid && out0_ready;
    assign pop1        = out1_valid && out1_ready;
    assign count0_next = next_count(count0, push0, pop0);
    assign count1_next = next_count(count1, push1, pop1);

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    logic  first_q;
    dest_e lock_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q    <= 1'b1;
            lock_sel_q <= DEST_OUT0;
        end else if (accept) begin
            first_q <= in_last;
            if (first_q) begin
                lock_sel_q <= dest_e'(in_sel);
            end
        end
    end

    // Next beat's target is only known while a packet is still open.
    always_comb begin
        eff_sel        = first_q ? dest_e'(in_sel) : lock_sel_q;
        next_sel_known = accept ? !in_last : !first_q;
        next_sel       = (accept && first_q) ? dest_e'(in_sel) : lock_sel_q;
    end
`else
    logic unused_last;
    assign unused_last = in_last;

    always_comb begin
        eff_sel        = dest_e'(in_sel);
        next_sel_known = 1'b0;
        next_sel       = DEST_OUT0;
    end
`endif

    // Unknown next destination means both buffers must have room.
    always_comb begin
        room_next = (count0_next < SKID_FULL) && (count1_next < SKID_FULL);
        if (next_sel_known) begin
            room_next = (next_sel == DEST_OUT0) ? (count0_next < SKID_FULL)
                                                : (count1_next < SKID_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= room_next;
        end
    end

    skid_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .pop       (pop0),
        .head_data (out0_data),
        .count     (count0)
    );

    skid_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .head_data (out1_data),
        .count     (count1)
    );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2; the packet sequence expects locked routing
// when STREAM_DEMUX_PKT_LOCK_EN is defined and per-beat routing otherwise.
module tb_stream_demux_1to2;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_sel, in_last;
    logic [7:0] in_data;
    logic       out0_valid, out0_ready, out1_valid, out1_ready;
    logic [7:0] out0_data, out1_data;

    int test_count = 0;
    int fail_count = 0;

    typedef struct {
        logic       rst, vld;
        logic [7:0] data;
        logic       sel, r0, r1;
        logic       e_ir, e_v0;
        logic [7:0] e_d0;
        logic       e_v1;
        logic [7:0] e_d1;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    stream_demux_1to2 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
    );

    function automatic vec_t mk(input logic r, v, input logic [7:0] d, input logic s, r0, r1,
                                input logic ir, v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1);
        vec_t x;
        x.rst = r;  x.vld = v;  x.data = d;  x.sel = s;  x.r0 = r0;  x.r1 = r1;
        x.e_ir = ir; x.e_v0 = v0; x.e_d0 = d0; x.e_v1 = v1; x.e_d1 = d1;
        return x;
    endfunction

    task automatic applyStimulus(input logic r, v, input logic [7:0] d,
                                 input logic s, l, r0, r1);
        rst        = r;
        in_valid   = v;
        in_data    = d;
        in_sel     = s;
        in_last    = l;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);

        // rst, vld, data, sel, r0, r1 | in_ready, v0, d0, v1, d1 (seen before the edge)
        vecs.push_back(mk(1,0,8'h00,0,1,1, 0,0,8'h00,0,8'h00));
        vecs.push_back(mk(0,1,8'h11,0,1,1, 1,0,8'h00,0,8'h00));
        vecs.push_back(mk(0,1,8'h22,1,1,1, 1,1,8'h11,0,8'h00));
        vecs.push_back(mk(0,1,8'h33,0,1,1, 1,0,8'h00,1,8'h22));
        vecs.push_back(mk(0,1,8'h44,1,1,1, 1,1,8'h33,0,8'h00));
        vecs.push_back(mk(0,0,8'h00,0,1,1, 1,0,8'h00,1,8'h44));
        vecs.push_back(mk(0,0,8'h00,0,1,1, 1,0,8'h00,0,8'h00));
        vecs.push_back(mk(0,1,8'hA0,0,0,1, 1,0,8'h00,0,8'h00));
        vecs.push_back(mk(0,1,8'hA1,0,0,1, 1,1,8'hA0,0,8'h00));
        vecs.push_back(mk(0,1,8'hA2,0,0,1, 0,1,8'hA0,0,8'h00));
        vecs.push_back(mk(0,1,8'hB0,1,0,1, 0,1,8'hA0,0,8'h00));
        vecs.push_back(mk(0,1,8'hB0,1,1,1, 0,1,8'hA0,0,8'h00));
        vecs.push_back(mk(0,1,8'hB0,1,1,1, 1,1,8'hA1,0,8'h00));
        vecs.push_back(mk(0,0,8'h00,0,1,1, 1,0,8'h00,1,8'hB0));
        vecs.push_back(mk(0,0,8'h00,0,1,1, 1,0,8'h00,0,8'h00));
        vecs.push_back(mk(0,1,8'hC0,0,0,1, 1,0,8'h00,0,8'h00));
        vecs.push_back(mk(0,1,8'hC1,0,0,1, 1,1,8'hC0,0,8'h00));
        vecs.push_back(mk(0,1,8'hC2,0,1,1, 0,1,8'hC0,0,8'h00));
        vecs.push_back(mk(0,1,8'hC2,0,1,1, 1,1,8'hC1,0,8'h00));
        vecs.push_back(mk(0,0,8'h00,0,1,1, 1,1,8'hC2,0,8'h00));
        vecs.push_back(mk(0,0,8'h00,0,1,1, 1,0,8'h00,0,8'h00));

        // Every table beat is a one-beat packet so both builds route by in_sel.
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].sel,
                          1'b1, vecs[i].r0, vecs[i].r1);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            checkOutput($sformatf("vec%0d_out0_valid", i), 32'(out0_valid), 32'(vecs[i].e_v0));
            checkOutput($sformatf("vec%0d_out1_valid", i), 32'(out1_valid), 32'(vecs[i].e_v1));
            if (vecs[i].e_v0)
                checkOutput($sformatf("vec%0d_out0_data", i), 32'(out0_data), 32'(vecs[i].e_d0));
            if (vecs[i].e_v1)
                checkOutput($sformatf("vec%0d_out1_data", i), 32'(out1_data), 32'(vecs[i].e_d1));
        end

        // Sixteen back-to-back beats to out1, each visible one cycle after acceptance.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, 8'(8'h50 + i), 1'b1, 1'b1, 1'b1, 1'b1);
            #1;
            checkOutput($sformatf("tput%0d_in_ready", i), 32'(in_ready), 32'd1);
            if (i > 0) begin
                checkOutput($sformatf("tput%0d_out1_valid", i), 32'(out1_valid), 32'd1);
                checkOutput($sformatf("tput%0d_out1_data", i), 32'(out1_data), 32'(8'h50 + i - 1));
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("tput_tail_valid", 32'(out1_valid), 32'd1);
        checkOutput("tput_tail_data", 32'(out1_data), 32'h5F);
        @(negedge clk);
        #1;
        checkOutput("tput_drained", 32'(out1_valid), 32'd0);

        // Fill out0 to two beats and out1 to one, then reset while they are stalled.
        @(negedge clk); applyStimulus(1'b0, 1'b1, 8'hD0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); applyStimulus(1'b0, 1'b1, 8'hD1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); applyStimulus(1'b0, 1'b1, 8'hD2, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rst_pre_out0_valid", 32'(out0_valid), 32'd1);
        checkOutput("rst_pre_out1_valid", 32'(out1_valid), 32'd1);
        checkOutput("rst_high_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("rst_out0_valid", 32'(out0_valid), 32'd0);
        checkOutput("rst_out1_valid", 32'(out1_valid), 32'd0);
        checkOutput("rst_out0_data", 32'(out0_data), 32'd0);
        checkOutput("rst_out1_data", 32'(out1_data), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("rst_stale%0d_out0", i), 32'(out0_valid), 32'd0);
            checkOutput($sformatf("rst_stale%0d_out1", i), 32'(out1_valid), 32'd0);
        end

        // Three-beat packet with sel 1,0,0 then a one-beat packet with sel 0.
        @(negedge clk); applyStimulus(1'b0, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("pkt1_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); applyStimulus(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("pkt2_in_ready", 32'(in_ready), 32'd1);
        checkOutput("pkt2_out1_valid", 32'(out1_valid), 32'd1);
        checkOutput("pkt2_out1_data", 32'(out1_data), 32'hE0);
        checkOutput("pkt2_out0_valid", 32'(out0_valid), 32'd0);
        @(negedge clk); applyStimulus(1'b0, 1'b1, 8'hE2, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("pkt3_in_ready", 32'(in_ready), 32'd1);
        checkOutput("pkt3_out1_valid", 32'(out1_valid), 32'(LOCK_EN));
        checkOutput("pkt3_out0_valid", 32'(out0_valid), 32'(!LOCK_EN));
        checkOutput("pkt3_data", 32'(LOCK_EN ? out1_data : out0_data), 32'hE1);
        @(negedge clk); applyStimulus(1'b0, 1'b1, 8'hE3, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("pkt4_in_ready", 32'(in_ready), 32'd1);
        checkOutput("pkt4_out1_valid", 32'(out1_valid), 32'(LOCK_EN));
        checkOutput("pkt4_out0_valid", 32'(out0_valid), 32'(!LOCK_EN));
        checkOutput("pkt4_data", 32'(LOCK_EN ? out1_data : out0_data), 32'hE2);
        @(negedge clk); applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("pkt5_out0_valid", 32'(out0_valid), 32'd1);
        checkOutput("pkt5_out0_data", 32'(out0_data), 32'hE3);
        checkOutput("pkt5_out1_valid", 32'(out1_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
